// File: rtl/sequence_bit_serializer.sv
// -----------------------------------------------------------------------------
// sequence_bit_serializer
//
// Parallel-to-serial front end for the Moore sequence detector. WIDTH-bit
// words are accepted over a valid/ready handshake and sent one bit per clock
// on sequence_out. A word that arrives on the last-bit cycle of the previous
// word is loaded without an idle cycle. This keeps a pattern that straddles a
// word boundary contiguous on the detector's serial input.
//
// Parameters
//   WIDTH      bits per word, legal range 2..32
//   LSB_FIRST  0: data_in[WIDTH-1] is sent first, 1: data_in[0] is sent first
//   IDLE_BIT   level driven on sequence_out while no payload bit is sent
//
// Ports
//   clock         in   rising-edge clock, single domain
//   reset         in   synchronous, active-high reset
//   data_in       in   word to serialize, sampled on a handshake edge
//   data_valid    in   producer offers a word on data_in
//   data_ready    out  serializer accepts a word this cycle (from state only)
//   sequence_out  out  registered serial bit stream
//   bit_valid     out  sequence_out carries a payload bit this cycle
//   word_done     out  last bit of a word is on sequence_out this cycle
//   word_count    out  number of fully sent words, wraps 0xFFFF -> 0x0000
// -----------------------------------------------------------------------------
module sequence_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic [15:0]      word_count
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // The bit that goes out next always sits at the "head" of the word. The
    // head is the MSB for MSB-first and the LSB for LSB-first.
    function automatic logic head_bit(input logic [WIDTH-1:0] word);
        logic result;
        if (LSB_FIRST) begin
            result = word[0];
        end else begin
            result = word[WIDTH-1];
        end
        return result;
    endfunction

    // Move the next bit into the head position.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] result;
        if (LSB_FIRST) begin
            result = {1'b0, word[WIDTH-1:1]};
        end else begin
            result = {word[WIDTH-2:0], 1'b0};
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] shift_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             sequence_out_r;
    logic             bit_valid_r;
    logic             word_done_r;
    logic [15:0]      word_count_r;

    logic             last_bit_s;
    logic             ready_s;
    logic             take_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] shift_next_s;
    logic [CNT_W-1:0] bit_cnt_next_s;
    logic             sequence_next_s;
    logic             bit_valid_next_s;
    logic             word_done_next_s;
    logic             count_inc_s;

    // Shared handshake decode. The head of shift_r is the bit currently on
    // sequence_out, so bit_cnt_r == LAST_CNT marks the last-bit cycle.
    assign last_bit_s = (state_r == ST_SHIFT) && (bit_cnt_r == LAST_CNT);
    assign ready_s    = (state_r == ST_IDLE) || last_bit_s;
    assign data_ready = ~reset & ready_s;
    assign take_s     = data_ready & data_valid;
    assign shifted_s  = shift_once(shift_r);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s && !take_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath logic. This block computes the values that the
    // output registers take at the next edge.
    always_comb begin
        shift_next_s     = shift_r;
        bit_cnt_next_s   = bit_cnt_r;
        sequence_next_s  = IDLE_BIT;
        bit_valid_next_s = 1'b0;
        word_done_next_s = 1'b0;
        count_inc_s      = last_bit_s;
        if (take_s) begin
            // A new word takes priority. On the last-bit cycle this is the
            // gapless reload. WIDTH >= 2, so the first bit is never the last.
            shift_next_s     = data_in;
            bit_cnt_next_s   = {CNT_W{1'b0}};
            sequence_next_s  = head_bit(data_in);
            bit_valid_next_s = 1'b1;
            word_done_next_s = 1'b0;
        end else if ((state_r == ST_SHIFT) && !last_bit_s) begin
            shift_next_s     = shifted_s;
            bit_cnt_next_s   = bit_cnt_r + CNT_W'(1);
            sequence_next_s  = head_bit(shifted_s);
            bit_valid_next_s = 1'b1;
            word_done_next_s = (bit_cnt_r + CNT_W'(1)) == LAST_CNT;
        end else begin
            // Idle, or the word just ended with no follow-on word.
            bit_cnt_next_s   = {CNT_W{1'b0}};
        end
    end

    // Datapath and output registers. A reset during a word drops the word
    // without counting it.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_r        <= {WIDTH{1'b0}};
            bit_cnt_r      <= {CNT_W{1'b0}};
            sequence_out_r <= IDLE_BIT;
            bit_valid_r    <= 1'b0;
            word_done_r    <= 1'b0;
            word_count_r   <= 16'h0000;
        end else begin
            shift_r        <= shift_next_s;
            bit_cnt_r      <= bit_cnt_next_s;
            sequence_out_r <= sequence_next_s;
            bit_valid_r    <= bit_valid_next_s;
            word_done_r    <= word_done_next_s;
            if (count_inc_s) begin
                word_count_r <= word_count_r + 16'h0001;
            end else begin
                word_count_r <= word_count_r;
            end
        end
    end

    assign sequence_out = sequence_out_r;
    assign bit_valid    = bit_valid_r;
    assign word_done    = word_done_r;
    assign word_count   = word_count_r;

endmodule

// File: tb/tb_sequence_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_sequence_bit_serializer
//
// Directed bench for sequence_bit_serializer. The main instance is MSB-first
// with IDLE_BIT=0. A second instance is LSB-first with IDLE_BIT=1. Expected
// bit streams are written out by hand. Each array's first-sent bit is at the
// top index.
// -----------------------------------------------------------------------------
module tb_sequence_bit_serializer;

    logic        clock;
    logic        reset;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        sequence_out;
    logic        bit_valid;
    logic        word_done;
    logic [15:0] word_count;

    logic [7:0]  data2_in;
    logic        data2_valid;
    logic        data2_ready;
    logic        sequence2_out;
    logic        bit2_valid;
    logic        word2_done;
    logic [15:0] word2_count;

    int pass_cnt;
    int total_cnt;

    sequence_bit_serializer #(
        .WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .sequence_out(sequence_out), .bit_valid(bit_valid),
        .word_done(word_done), .word_count(word_count)
    );

    sequence_bit_serializer #(
        .WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)
    ) dut_lsb (
        .clock(clock), .reset(reset), .data_in(data2_in), .data_valid(data2_valid),
        .data_ready(data2_ready), .sequence_out(sequence2_out), .bit_valid(bit2_valid),
        .word_done(word2_done), .word_count(word2_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one clock. Outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
        data2_valid = 1'b0; data2_in = 8'h00;
        step(); step();
        total_cnt++;
        if ({sequence_out, bit_valid, word_done, data_ready} !== 4'b0000) begin
            $display("FAIL reset_outputs: got %b want 0000", {sequence_out, bit_valid, word_done, data_ready});
        end else pass_cnt++;
        total_cnt++;
        if (word_count !== 16'h0000) begin
            $display("FAIL reset_count: got %h want 0000", word_count);
        end else pass_cnt++;
        total_cnt++;
        if ({sequence2_out, bit2_valid, data2_ready} !== 3'b100) begin
            $display("FAIL reset_lsb_idle: got %b want 100", {sequence2_out, bit2_valid, data2_ready});
        end else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (data_ready !== 1'b1) begin
            $display("FAIL ready_after_reset: got %b want 1", data_ready);
        end else pass_cnt++;
    endtask

    // 8'h90 MSB-first gives 1,0,0,1,0,0,0,0.
    task automatic test_single();
        logic [7:0] exp_bits;
        exp_bits = 8'b1001_0000;
        data_in = 8'h90; data_valid = 1'b1;
        step();
        data_valid = 1'b0; data_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if ({sequence_out, bit_valid, word_done, data_ready} !== {exp_bits[7-i], 1'b1, i == 7, i == 7}) begin
                $display("FAIL single_bit%0d: got %b want %b", i,
                         {sequence_out, bit_valid, word_done, data_ready}, {exp_bits[7-i], 1'b1, i == 7, i == 7});
            end else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({sequence_out, bit_valid, word_done, word_count} !== {3'b000, 16'h0001}) begin
            $display("FAIL single_idle: got %b/%h want 000/0001", {sequence_out, bit_valid, word_done}, word_count);
        end else pass_cnt++;
    endtask

    // The A5 and 3C words stream with no gap.
    task automatic test_back_to_back();
        logic [15:0] exp_bits;
        exp_bits = 16'b1010_0101_0011_1100;
        data_in = 8'hA5; data_valid = 1'b1;
        step();
        data_in = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if ({sequence_out, bit_valid, word_done, data_ready} !==
                {exp_bits[15-i], 1'b1, (i == 7) || (i == 15), (i == 7) || (i == 15)}) begin
                $display("FAIL b2b_bit%0d: got %b want %b", i, {sequence_out, bit_valid, word_done, data_ready},
                         {exp_bits[15-i], 1'b1, (i == 7) || (i == 15), (i == 7) || (i == 15)});
            end else pass_cnt++;
            step();
            if (i == 7) data_valid = 1'b0;
        end
        total_cnt++;
        if ({sequence_out, bit_valid, data_ready, word_count} !== {3'b001, 16'h0003}) begin
            $display("FAIL b2b_idle: got %b/%h want 001/0003", {sequence_out, bit_valid, data_ready}, word_count);
        end else pass_cnt++;
    endtask

    // 8'h09 LSB-first gives 1,0,0,1,0,0,0,0, and the idle level is 1.
    task automatic test_lsb_first();
        logic [7:0] exp_bits;
        exp_bits = 8'b1001_0000;
        data2_in = 8'h09; data2_valid = 1'b1;
        step();
        data2_valid = 1'b0; data2_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if ({sequence2_out, bit2_valid, word2_done, data2_ready} !== {exp_bits[7-i], 1'b1, i == 7, i == 7}) begin
                $display("FAIL lsb_bit%0d: got %b want %b", i,
                         {sequence2_out, bit2_valid, word2_done, data2_ready}, {exp_bits[7-i], 1'b1, i == 7, i == 7});
            end else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({sequence2_out, bit2_valid, word2_count} !== {2'b10, 16'h0001}) begin
            $display("FAIL lsb_idle: got %b/%h want 10/0001", {sequence2_out, bit2_valid}, word2_count);
        end else pass_cnt++;
    endtask

    // Reset on the 4th bit of 8'hFF drops the word. The next word goes out in full.
    task automatic test_reset_mid_word();
        logic [7:0] exp_bits;
        exp_bits = 8'b0101_1010;
        data_in = 8'hFF; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step(); step(); step();
        total_cnt++;
        if ({sequence_out, bit_valid} !== 2'b11) begin
            $display("FAIL midrst_4th_bit: got %b want 11", {sequence_out, bit_valid});
        end else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (data_ready !== 1'b0) begin
            $display("FAIL midrst_ready: got %b want 0", data_ready);
        end else pass_cnt++;
        step();
        reset = 1'b0;
        total_cnt++;
        if ({sequence_out, bit_valid, word_done, word_count} !== {3'b000, 16'h0000}) begin
            $display("FAIL midrst_after: got %b/%h want 000/0000", {sequence_out, bit_valid, word_done}, word_count);
        end else pass_cnt++;
        data_in = 8'h5A; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if ({sequence_out, bit_valid, word_done} !== {exp_bits[7-i], 1'b1, i == 7}) begin
                $display("FAIL midrst_new_bit%0d: got %b want %b", i,
                         {sequence_out, bit_valid, word_done}, {exp_bits[7-i], 1'b1, i == 7});
            end else pass_cnt++;
            step();
        end
        total_cnt++;
        if (word_count !== 16'h0001) begin
            $display("FAIL midrst_count: got %h want 0001", word_count);
        end else pass_cnt++;
    endtask

    // Producer stalls. Word C3 is followed by two idle cycles. Word 81 then
    // runs while a held data_valid presents 7E, which is taken without a gap.
    task automatic test_stalls();
        logic [7:0]  exp_c3;
        logic [15:0] exp_pair;
        exp_c3   = 8'b1100_0011;
        exp_pair = 16'b1000_0001_0111_1110;
        data_in = 8'hC3; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if ({sequence_out, bit_valid} !== {exp_c3[7-i], 1'b1}) begin
                $display("FAIL stall_c3_bit%0d: got %b want %b", i, {sequence_out, bit_valid}, {exp_c3[7-i], 1'b1});
            end else pass_cnt++;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if ({sequence_out, bit_valid, data_ready} !== 3'b001) begin
                $display("FAIL stall_gap%0d: got %b want 001", i, {sequence_out, bit_valid, data_ready});
            end else pass_cnt++;
            step();
        end
        data_in = 8'h81; data_valid = 1'b1;
        step();
        data_valid = 1'b0; data_in = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if ({sequence_out, bit_valid, data_ready} !== {exp_pair[15-i], 1'b1, (i == 7) || (i == 15)}) begin
                $display("FAIL stall_pair_bit%0d: got %b want %b", i, {sequence_out, bit_valid, data_ready},
                         {exp_pair[15-i], 1'b1, (i == 7) || (i == 15)});
            end else pass_cnt++;
            if (i == 2) begin
                data_in = 8'h7E; data_valid = 1'b1;
            end
            step();
            if (i == 7) data_valid = 1'b0;
        end
        total_cnt++;
        if ({sequence_out, bit_valid, word_count} !== {2'b00, 16'h0004}) begin
            $display("FAIL stall_end: got %b/%h want 00/0004", {sequence_out, bit_valid}, word_count);
        end else pass_cnt++;
    endtask

    // Preload the counter to FFFE, then two words give FFFF and then 0000.
    task automatic test_count_wrap();
        force dut.word_count_r = 16'hFFFE;
        step();
        release dut.word_count_r;
        #1;
        total_cnt++;
        if (word_count !== 16'hFFFE) begin
            $display("FAIL wrap_preload: got %h want FFFE", word_count);
        end else pass_cnt++;
        data_in = 8'h01; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        total_cnt++;
        if (word_count !== 16'hFFFF) begin
            $display("FAIL wrap_ffff: got %h want FFFF", word_count);
        end else pass_cnt++;
        data_in = 8'h80; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        total_cnt++;
        if ({word_done, word_count} !== {1'b1, 16'hFFFF}) begin
            $display("FAIL wrap_last_bit: got %b/%h want 1/FFFF", word_done, word_count);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({bit_valid, word_count} !== {1'b0, 16'h0000}) begin
            $display("FAIL wrap_zero: got %b/%h want 0/0000", bit_valid, word_count);
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_word();
        test_stalls();
        test_count_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
